dmem_responder: RTL

//  Memory-side responder for core load/store traffic over a valid/ready request/response channel.

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM encoding,
// default region base and the latched request record.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Data region base; the same constant anchors the PC_INIT region map.
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension, and alignment check.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata_al  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    shifted   = rword >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_al  = {2{wdata[15:0]}};
        rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misalign  = |addr_lo;
        be        = 4'b1111;
        wdata_al  = wdata;
        rdata_ext = rword;
      end
      default: ;  // illegal size is flagged by the caller
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed access latency over
// valid/ready request and response channels, backed by an internal word array.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 2) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       off, rword, wdata_al, rdata_ext;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic              misalign, err, mem_we;

  // Unsigned subtract: addresses below the base wrap high and fail the range check.
  assign off   = req_q.addr - BASE_ADDR;
  assign idx   = IDX_W'(off >> 2);
  assign rword = mem[idx];
  assign err   = (req_q.size == SZ_ILL) || misalign || (off >= SPAN);

  dmem_lane_align u_align (
    .addr_lo   (req_q.addr[1:0]),
    .size      (req_q.size),
    .sgn       (req_q.sgn),
    .rword     (rword),
    .wdata     (req_q.wdata),
    .be        (be),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_d.rw    = req_rw;
          req_d.addr  = req_addr;
          req_d.size  = req_size;
          req_d.sgn   = req_signed;
          req_d.wdata = req_wdata;
          req_ready_d = 1'b0;
          cnt_d       = CNT_INIT;
          state_d     = (LATENCY == 1) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        mem_we      = req_q.rw && !err;
        err_d       = err;
        rdata_d     = (err || req_q.rw) ? 32'h0 : rdata_ext;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Array is not reset; reset forces IDLE so a pending store never commits.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
